// File: rtl/wide_add_ctrl_if.sv
// Handshake and adder-port bundle for the wide add/subtract sequencer.
// The slave view belongs to the sequencer; the master view belongs to
// whatever issues operations and supplies the shared 32-bit adder.
interface wide_add_ctrl_if #(
    parameter int WORDS = 4
);
    // Request side
    logic                  start;
    logic                  op_sub;
    logic [32*WORDS-1:0]   a_in;
    logic [32*WORDS-1:0]   b_in;
    // Status / result side
    logic                  ready;
    logic                  done;
    logic [32*WORDS-1:0]   result;
    logic                  c_out;
    logic                  overflow;
    // Shared external adder
    logic [31:0]           adder_a;
    logic [31:0]           adder_b;
    logic                  adder_cin;
    logic [31:0]           adder_sum;
    logic                  adder_cout;

    modport slave (
        input  start, op_sub, a_in, b_in, adder_sum, adder_cout,
        output ready, done, result, c_out, overflow,
               adder_a, adder_b, adder_cin
    );

    modport master (
        output start, op_sub, a_in, b_in, adder_sum, adder_cout,
        input  ready, done, result, c_out, overflow,
               adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/wide_add_ctrl.sv
// Multi-word add/subtract sequencer. One external 32-bit adder is reused
// once per word, least significant word first, with the carry chained
// through a register. Subtraction is A + ~B + 1: B is inverted on
// capture and the initial carry-in is the op_sub bit.
// All outputs, including the adder operand ports, come straight from flops.
module wide_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    wide_add_ctrl_if.slave   bus
);
    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;          // effective B (already inverted for subtract)
    logic               carry_q;
    logic [IDXW-1:0]    idx_q;
    logic [W-1:0]       result_q;
    logic               c_out_q;
    logic               overflow_q;
    logic               ready_q;
    logic               done_q;
    logic [31:0]        adder_a_q;
    logic [31:0]        adder_b_q;
    logic               adder_cin_q;

    logic [W-1:0]       b_eff_s;
    logic [IDXW-1:0]    idx_nxt_s;
    logic [31:0]        a_word_nxt_s;
    logic [31:0]        b_word_nxt_s;
    logic               ovf_s;

    // Operand preparation: effective B, the next word to present to the adder, and signed overflow of the top word
    always_comb begin
        b_eff_s      = '0;
        idx_nxt_s    = '0;
        a_word_nxt_s = 32'd0;
        b_word_nxt_s = 32'd0;
        ovf_s        = 1'b0;

        if (bus.op_sub) begin
            b_eff_s = ~bus.b_in;
        end else begin
            b_eff_s = bus.b_in;
        end

        if (idx_q == LAST) begin
            idx_nxt_s = '0;
        end else begin
            idx_nxt_s = idx_q + IDXW'(1);
        end

        a_word_nxt_s = a_q[32*int'(idx_nxt_s) +: 32];
        b_word_nxt_s = b_q[32*int'(idx_nxt_s) +: 32];

        // Same-sign operands producing an opposite-sign result
        ovf_s = (a_q[W-1] == b_q[W-1]) && (bus.adder_sum[31] != a_q[W-1]);
    end

    // Sequencer FSM: captures operands, steps one word per cycle, publishes result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            adder_a_q   <= 32'd0;
            adder_b_q   <= 32'd0;
            adder_cin_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q         <= bus.a_in;
                        b_q         <= b_eff_s;
                        carry_q     <= bus.op_sub;
                        idx_q       <= '0;
                        result_q    <= '0;
                        ready_q     <= 1'b0;
                        // Word 0 is presented to the adder in the first RUN cycle
                        adder_a_q   <= bus.a_in[31:0];
                        adder_b_q   <= b_eff_s[31:0];
                        adder_cin_q <= bus.op_sub;
                        state_q     <= S_RUN;
                    end else begin
                        ready_q     <= 1'b1;
                    end
                end

                S_RUN: begin
                    result_q[32*int'(idx_q) +: 32] <= bus.adder_sum;
                    carry_q <= bus.adder_cout;
                    if (idx_q == LAST) begin
                        c_out_q     <= bus.adder_cout;
                        overflow_q  <= ovf_s;
                        done_q      <= 1'b1;
                        adder_a_q   <= 32'd0;
                        adder_b_q   <= 32'd0;
                        adder_cin_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q       <= idx_nxt_s;
                        adder_a_q   <= a_word_nxt_s;
                        adder_b_q   <= b_word_nxt_s;
                        adder_cin_q <= bus.adder_cout;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    idx_q       <= '0;
                    carry_q     <= 1'b0;
                    adder_a_q   <= 32'd0;
                    adder_b_q   <= 32'd0;
                    adder_cin_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.adder_a   = adder_a_q;
    assign bus.adder_b   = adder_b_q;
    assign bus.adder_cin = adder_cin_q;

endmodule

// File: tb/tb_wide_add_ctrl.sv
// Scoreboard bench for wide_add_ctrl (WORDS=4). Stimulus pushes the
// hand-computed expected result; a monitor pops and compares on done.
module tb_wide_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   n_done;
    exp_t sb_q[$];

    wide_add_ctrl_if #(.WORDS(WORDS)) bus ();

    wide_add_ctrl #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 32-bit ripple adder shared by the sequencer
    assign {bus.adder_cout, bus.adder_sum} =
        {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {32'd0, bus.adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is checked against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            n_done++;
            n_cmp++;
            if (bus.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_with_done: got ready=%b required 0", bus.ready);
            end
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard, required none");
            end else begin
                e = sb_q.pop_front();
                if (bus.result !== e.r || bus.c_out !== e.c || bus.overflow !== e.v) begin
                    n_fail++;
                    $display("FAIL result: got r=%h c=%b v=%b required r=%h c=%b v=%b",
                             bus.result, bus.c_out, bus.overflow, e.r, e.c, e.v);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b required 1", bus.ready);
        end
    endtask

    // Drive one request and return just after the accepting edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bus.a_in   = a;
        bus.b_in   = b;
        bus.op_sub = sub;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic ev);
        exp_t e;
        wait_ready();
        e.r = er;
        e.c = ec;
        e.v = ev;
        sb_q.push_back(e);
        issue(a, b, sub);
    endtask

    initial begin
        exp_t e;
        int   d0;
        logic [W-1:0] ones;
        logic [W-1:0] max_pos;
        logic [W-1:0] min_neg;

        n_cmp = 0; n_fail = 0; n_done = 0;
        ones    = {W{1'b1}};
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        bus.start = 1'b0; bus.op_sub = 1'b0;
        bus.a_in = '0; bus.b_in = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",    W'(bus.ready),    W'(1));
        chk("rst_done",     W'(bus.done),     W'(0));
        chk("rst_result",   bus.result,       W'(0));
        chk("rst_cout",     W'(bus.c_out),    W'(0));
        chk("rst_overflow", W'(bus.overflow), W'(0));

        // Carry ripple across all words, with latency and per-word carry-in
        wait_ready();
        e.r = '0; e.c = 1'b1; e.v = 1'b0;
        sb_q.push_back(e);
        issue(ones, W'(1), 1'b0);
        for (int w = 0; w < WORDS; w++) begin
            @(negedge clk);
            chk($sformatf("carry_cin_w%0d", w), W'(bus.adder_cin), (w == 0) ? W'(0) : W'(1));
            chk($sformatf("carry_notdone_w%0d", w), W'(bus.done), W'(0));
        end
        @(negedge clk);
        chk("carry_latency_done", W'(bus.done), W'(1));

        // Signed overflow on add
        run_op(max_pos, W'(1), 1'b0, min_neg, 1'b0, 1'b1);
        // Subtract with borrow
        run_op(W'(5), W'(7), 1'b1, {{(W-8){1'b1}}, 8'hFE}, 1'b0, 1'b0);
        // Subtract without borrow
        run_op(W'(7), W'(5), 1'b1, W'(2), 1'b1, 1'b0);
        // Signed overflow on subtract: most negative minus one
        run_op(min_neg, W'(1), 1'b1, max_pos, 1'b1, 1'b1);
        // Mixed per-word carries
        run_op(128'h00000001_80000000_FFFFFFFF_12345678,
               128'h00000002_80000000_00000001_11111111, 1'b0,
               128'h00000004_00000001_00000000_23456789, 1'b0, 1'b0);

        // Busy-start rejection
        wait_ready();
        d0 = n_done;
        e.r = W'(2); e.c = 1'b0; e.v = 1'b0;
        sb_q.push_back(e);
        issue(W'(1), W'(1), 1'b0);
        @(negedge clk);
        chk("busy_ready_run0", W'(bus.ready), W'(0));
        @(posedge clk);
        #1;
        issue(W'(9), W'(9), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("busy_ready_low%0d", i), W'(bus.ready), W'(0));
        end
        wait_ready();
        repeat (8) @(posedge clk);
        #1;
        chk("busy_single_done", W'(n_done - d0), W'(1));
        chk("busy_result", bus.result, W'(2));

        // Reset in the middle of RUN (idx=2)
        wait_ready();
        issue(W'(16), W'(32), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready",  W'(bus.ready),     W'(1));
        chk("mid_rst_done",   W'(bus.done),      W'(0));
        chk("mid_rst_result", bus.result,        W'(0));
        chk("mid_rst_adder_a", W'(bus.adder_a),  W'(0));
        chk("mid_rst_adder_b", W'(bus.adder_b),  W'(0));
        chk("mid_rst_cin",    W'(bus.adder_cin), W'(0));
        run_op(W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0);

        // Drain scoreboard
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", W'(sb_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wide_add_ctrl.md
Name: wide_add_ctrl

Overview:
- Multi-cycle sequencer that performs WORDS×32-bit add/subtract by time-multiplexing one external 32-bit ripple adder (FA32b-style: a, b, c_in → sum, c_out).
- Processes one 32-bit word per cycle, LSW first, and chains the carry through a register.
- Exposes a start/ready/done handshake to the issuing logic.
- Drives the adder's operand and carry-in ports directly; the adder path is combinational within one cycle.

Parameters:
WORDS, 4, number of 32-bit words per operand (total width 32*WORDS); legal range 2..8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only when ready=1
op_sub  input  1  0 = A+B, 1 = A−B (two's complement); sampled with start
a_in  input  32*WORDS  operand A; sampled with start
b_in  input  32*WORDS  operand B; sampled with start
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse when result is valid
result  output  32*WORDS  sum/difference; held until next accepted start
c_out  output  1  final carry out of MSW; held with result
overflow  output  1  signed overflow of the full-width op; held with result
adder_a  output  32  operand A word to adder
adder_b  output  32  effective operand B word to adder
adder_cin  output  1  carry-in to adder
adder_sum  input  32  adder sum, combinational from adder_a/adder_b/adder_cin
adder_cout  input  1  adder carry out

Behaviour:
- States: IDLE, RUN, DONE. Registers: a_reg, b_reg (effective B), carry_reg, idx (clog2(WORDS) bits), result, c_out, overflow.
- Reset (rst=1 at a clock edge), from any state including mid-RUN:
  - state→IDLE, idx→0, carry_reg→0.
  - result→0, c_out→0, overflow→0, done→0, ready→1.
  - No partial result survives.
- IDLE:
  - ready=1.
  - adder_a/adder_b/adder_cin driven 0.
  - On start=1:
    - a_reg←a_in.
    - b_reg←(op_sub ? ~b_in : b_in).
    - carry_reg←op_sub.
    - idx←0.
    - result←0.
    - state→RUN.
- RUN:
  - ready=0.
  - adder_a=a_reg[32*idx +: 32], adder_b=b_reg[32*idx +: 32], adder_cin=carry_reg.
  - Each edge: result[32*idx +: 32]←adder_sum; carry_reg←adder_cout.
  - If idx==WORDS−1:
    - c_out←adder_cout.
    - overflow←(a_reg MSB == b_reg MSB) && (adder_sum[31] != a_reg MSB).
    - state→DONE.
  - Otherwise idx←idx+1.
- DONE:
  - done=1 for exactly this cycle; ready=0; adder ports driven 0.
  - Next state always IDLE.
- Latency:
  - Start accepted at edge k.
  - RUN occupies cycles k+1..k+WORDS.
  - done high in cycle k+WORDS+1; ready returns in cycle k+WORDS+2.
  - Throughput: one op per WORDS+2 cycles.
- start while ready=0 is ignored; no queuing, no error flag.
- a_in/b_in/op_sub changes after acceptance have no effect on the current op.
- Outputs result/c_out/overflow remain stable from done until the next accepted start.
- c_out for subtraction follows the two's-complement convention: c_out=1 means no borrow.
- Wrap-around: full-width result is modulo 2^(32*WORDS); excess carry appears only on c_out.
- done and ready are never high in the same cycle.

Test Plan:
- Carry propagation across words, WORDS=4: start A=128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, op_sub=0 → done at cycle k+5, result=0, c_out=1, overflow=0; adder_cin=1 on words 1..3.
- Signed overflow: A=128'h7FFF…FFFF, B=1, add → result=128'h8000…0000, c_out=0, overflow=1.
- Subtract with borrow: A=5, B=7, op_sub=1 → result=128'hFFFF…FFFE, c_out=0, overflow=0.
- Subtract, no borrow: A=7, B=5, op_sub=1 → result=2, c_out=1.
- Busy-start rejection:
  - Pulse start with A=1, B=1, then pulse start again during RUN with A=9, B=9.
  - Required: result=2, single done pulse, ready low through RUN and DONE.
  - Second request is not executed.
- Reset mid-operation: assert rst at RUN idx=2 for one cycle.
  - Next cycle: state IDLE, ready=1, result=0, done=0, adder ports 0.
  - A new start of 3+4 then completes with result=7.
